prog_loader: RTL and testbench

- Byte-stream boot loader placed upstream of multi_cycle_cpu / single_cycle_cpu.
- Receives a length-prefixed program image over a valid/ready byte interface, for example from a UART RX.
- Assembles big-endian 32-bit words and writes them into the CPU instruction/unified RAM write port.
- Holds the CPU in reset until the image is fully written; this replaces $readmemh for on-board boot.

---
 rtl/loader_pkg.sv | 18 +
 rtl/byte_word_asm.sv | 29 ++
 rtl/prog_loader.sv | 137 +++++++++++++
 tb/tb_prog_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared state encoding and image-format constants for the byte-stream program loader.
// Bytes per word and the width of the word-count prefix live here so the FSM and assembler agree.
package loader_pkg;

   typedef enum logic [2:0] {
      LEN_HI,
      LEN_LO,
      WORD,
      WRITE,
      CSUM,
      DONE,
      ERROR
   } state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int LEN_W          = 16;

endpackage

// File: rtl/byte_word_asm.sv
// Big-endian 8->32 assembler: each shifted byte lands in the LSB, so the first byte ends up as the MSB.
// word_full is combinational and flags the shift that completes a word; the assembler never stalls.
module byte_word_asm
   import loader_pkg::*;
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic [7:0]                  in_byte,
   input  logic                        shift_en,
   input  logic                        clear,
   output logic [8*BYTES_PER_WORD-1:0] word,
   output logic                        word_full
);

   logic [1:0] byte_cnt;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         word     <= '0;
         byte_cnt <= '0;
      end else if (shift_en) begin
         word     <= {word[8*BYTES_PER_WORD-9:0], in_byte};
         byte_cnt <= byte_cnt + 2'd1;
      end
   end

   assign word_full = shift_en && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Boot loader: length-prefixed byte image -> 32-bit RAM writes, CPU held in reset until loaded; optional PROG_LOADER_CHECKSUM_EN.
// mem_we fires the cycle after a word's 4th byte; in_ready drops during WRITE/DONE/ERROR and the source holds its byte.
module prog_loader
   import loader_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              start,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              error
);

   state_t            state, state_nxt;
   logic [7:0]        len_hi;
   logic [LEN_W-1:0]  len;
   logic [LEN_W-1:0]  len_new;
   logic [ADDR_W-1:0] word_idx;
   logic              accept;
   logic              rearm;
   logic              last_word;
   logic              word_full;
   logic [31:0]       asm_word;
   state_t            finish_state;

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0] csum;
   assign finish_state = CSUM;
`else
   assign finish_state = DONE;
`endif

   assign accept    = in_valid && in_ready;
   assign rearm     = start && (state == DONE || state == ERROR);
   assign len_new   = {len_hi, in_data};
   assign last_word = (LEN_W'(word_idx) == len - LEN_W'(1));

   byte_word_asm u_asm (
      .clk       (clk),
      .reset     (reset),
      .in_byte   (in_data),
      .shift_en  (accept && state == WORD),
      .clear     (rearm),
      .word      (asm_word),
      .word_full (word_full)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= LEN_HI;
         len_hi   <= '0;
         len      <= '0;
         word_idx <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
         csum     <= '0;
`endif
      end else begin
         state <= state_nxt;
         if (rearm) begin
            len_hi   <= '0;
            len      <= '0;
            word_idx <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
         end else begin
            if (accept && state == LEN_HI) len_hi <= in_data;
            if (accept && state == LEN_LO) len <= len_new;
            // Index stays on the last word so it never wraps past MEM_DEPTH-1.
            if (state == WRITE && !last_word) word_idx <= word_idx + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            if (accept && state != CSUM) csum <= csum ^ in_data;
`endif
         end
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      mem_we    = 1'b0;
      cpu_reset = 1'b1;
      done      = 1'b0;
      error     = 1'b0;
      case (state)
         LEN_HI: begin
            in_ready = 1'b1;
            if (accept) state_nxt = LEN_LO;
         end
         LEN_LO: begin
            in_ready = 1'b1;
            if (accept) begin
               if (int'(len_new) > MEM_DEPTH) state_nxt = ERROR;
               else if (len_new == '0)        state_nxt = finish_state;
               else                           state_nxt = WORD;
            end
         end
         WORD: begin
            in_ready = 1'b1;
            if (word_full) state_nxt = WRITE;
         end
         WRITE: begin
            mem_we    = 1'b1;
            state_nxt = last_word ? finish_state : WORD;
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         CSUM: begin
            in_ready = 1'b1;
            if (accept) state_nxt = (in_data == csum) ? DONE : ERROR;
         end
`endif
         DONE: begin
            done      = 1'b1;
            cpu_reset = 1'b0;
            if (start) state_nxt = LEN_HI;
         end
         ERROR: begin
            error = 1'b1;
            if (start) state_nxt = LEN_HI;
         end
         default: state_nxt = LEN_HI;
      endcase
   end

   assign mem_addr  = word_idx;
   assign mem_wdata = asm_word;

endmodule

// File: tb/tb_prog_loader.sv
// Directed plus randomized image loads for prog_loader, checked against expected write lists built from the image.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        start;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_reset;
   logic        done;
   logic        error;

   int checks = 0;
   int errors = 0;

   prog_loader #(.MEM_DEPTH(256)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .start     (start),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_reset (cpu_reset),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   // Write monitor, sampled on the falling edge.
   int          cyc = 0;
   int          last_we_cyc = -1;
   int          done_cyc = -1;
   int          overlap = 0;
   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];

   always @(negedge clk) begin
      cyc++;
      if (mem_we) begin
         wa_q.push_back({24'd0, mem_addr});
         wd_q.push_back(mem_wdata);
         last_we_cyc = cyc;
         if (!cpu_reset) overlap++;
      end
      if (done && done_cyc < 0) done_cyc = cyc;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
      chk({tag, "_mem_we"},    {31'd0, mem_we},    32'd0);
      chk({tag, "_mem_addr"},  {24'd0, mem_addr},  32'd0);
      chk({tag, "_mem_wdata"}, mem_wdata,          32'd0);
      chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
      chk({tag, "_done"},      {31'd0, done},      32'd0);
      chk({tag, "_error"},     {31'd0, error},     32'd0);
   endtask

   // Caller is always at posedge+1 on entry and exit.
   task automatic send_byte(input logic [7:0] b, input int mode);
      logic ok;
      if (mode == 1) begin
         in_valid = 1'b0;
         @(posedge clk); #1;
      end else if (mode == 2) begin
         repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            start    = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            start    = 1'b0;
         end
      end
      in_data  = b;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
         if (in_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      chk("send_accept", {31'd0, ok}, 32'd1);
   endtask

   task automatic rearm();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("rearm_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rearm_done",      {31'd0, done},      32'd0);
      chk("rearm_error",     {31'd0, error},     32'd0);
      chk("rearm_cpu_reset", {31'd0, cpu_reset}, 32'd1);
   endtask

   // Reference: a legal header yields writes 0..n-1 of the image words in order,
   // then done (or error on a bad checksum); an oversize header yields only error.
   task automatic run_load(input string tag, input logic [15:0] n, input logic [31:0] words[$],
                           input int mode, input logic csum_bad);
      logic [7:0] bytes[$];
      logic [7:0] x;
      logic       hdr_err;
      logic       exp_err;
      int         exp_writes;
      hdr_err    = (int'(n) > 256);
      exp_err    = hdr_err || csum_bad;
      exp_writes = hdr_err ? 0 : int'(n);
      wa_q.delete();
      wd_q.delete();
      done_cyc    = -1;
      last_we_cyc = -1;
      bytes.push_back(n[15:8]);
      bytes.push_back(n[7:0]);
      for (int i = 0; i < exp_writes; i++)
         for (int k = 3; k >= 0; k--) bytes.push_back(8'(words[i] >> (8 * k)));
`ifdef PROG_LOADER_CHECKSUM_EN
      if (!hdr_err) begin
         x = 8'd0;
         foreach (bytes[i]) x ^= bytes[i];
         bytes.push_back(csum_bad ? (x ^ 8'h03) : x);
      end
`else
      x = 8'd0;
`endif
      foreach (bytes[i]) send_byte(bytes[i], mode);
      in_valid = 1'b0;
      for (int t = 0; t < 20 && !(done || error); t++) begin
         @(posedge clk); #1;
      end
      @(negedge clk); #1;
      chk({tag, "_nwrites"}, wa_q.size(), exp_writes);
      for (int i = 0; i < exp_writes && i < wa_q.size(); i++) begin
         chk({tag, "_addr"}, wa_q[i], i);
         chk({tag, "_data"}, wd_q[i], words[i]);
      end
      chk({tag, "_done"},      {31'd0, done},      {31'd0, !exp_err});
      chk({tag, "_error"},     {31'd0, error},     {31'd0, exp_err});
      chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, exp_err});
`ifndef PROG_LOADER_CHECKSUM_EN
      if (!exp_err && n != 16'd0)
         chk({tag, "_release_lat"}, done_cyc, last_we_cyc + 1);
`endif
   endtask

   initial begin
      logic [31:0] w[$];
      logic [31:0] big[$];
      int          n_r;
      int          mode_r;
      reset    = 1'b1;
      in_data  = 8'd0;
      in_valid = 1'b0;
      start    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("por");
      reset = 1'b0;
      @(posedge clk); #1;

      w = '{32'h2408000A, 32'h24090014, 32'h01095020};
      run_load("arith_held", 16'd3, w, 0, 1'b0);
      rearm();
      run_load("arith_toggle", 16'd3, w, 1, 1'b0);
      rearm();
      run_load("oversize_257", 16'h0101, w, 0, 1'b0);
      rearm();

      // Reset after two words of a four-word image, then a fresh one-word load.
      wa_q.delete();
      wd_q.delete();
      send_byte(8'h00, 0);
      send_byte(8'h04, 0);
      for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i), 0);
      in_valid = 1'b0;
      @(negedge clk); #1;
      chk("midload_nwrites", wa_q.size(), 2);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk_reset_vals("midload_reset");
      w = '{32'hDEADBEEF};
      run_load("after_reset", 16'd1, w, 0, 1'b0);
      rearm();

      big.delete();
      for (int i = 0; i < 256; i++) big.push_back($urandom);
      run_load("full_depth", 16'd256, big, 0, 1'b0);
      rearm();
      run_load("empty", 16'd0, big, 2, 1'b0);
      rearm();
      run_load("oversize_ffff", 16'hFFFF, big, 1, 1'b0);
      rearm();

      for (int r = 0; r < 6; r++) begin
         n_r    = $urandom_range(1, 12);
         mode_r = $urandom_range(0, 2);
         big.delete();
         for (int i = 0; i < n_r; i++) big.push_back($urandom);
         run_load("random", 16'(n_r), big, mode_r, 1'b0);
         rearm();
      end

`ifdef PROG_LOADER_CHECKSUM_EN
      w = '{32'h01020304};
      run_load("csum_good", 16'd1, w, 0, 1'b0);
      rearm();
      run_load("csum_bad", 16'd1, w, 0, 1'b1);
      rearm();
      run_load("csum_reload", 16'd1, w, 2, 1'b0);
`else
      w = '{32'h01020304};
      run_load("final", 16'd1, w, 0, 1'b0);
`endif

      // In DONE a presented byte must be held off and cause no write.
      n_r      = wa_q.size();
      in_data  = 8'hAA;
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_done",     {31'd0, done},     32'd1);
      @(negedge clk); #1;
      chk("hold_nwrites", wa_q.size(), n_r);
      in_valid = 1'b0;

      chk("we_while_released", overlap, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
